// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two memory requesters, the arbiter and the memory macro.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              boot_mode;
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              mem_re;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  boot_mode, req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
               mem_re, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output boot_mode, req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
               mem_re, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares a single-port memory between the core (port 0) and the boot loader (port 1),
// covering the memory's one-cycle read latency and routing read data to its issuer.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_arbiter_if.slave    bus
);
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_RD_WAIT = 1'b1;

    logic [0:0]        state_q, state_d;
    logic              rd_owner_q, rd_owner_d;
    logic              prio_q, prio_d;

    logic              elig0, elig1, win1, win_we;
    logic              gnt0, gnt1, rvalid0, rvalid1, mem_re, mem_we;
    logic [DATA_W-1:0] rdata0, rdata1, mem_wdata;
    logic [ADDR_W-1:0] mem_addr;

    // The core is invisible to arbitration while the loader owns memory in boot mode.
    always_comb begin
        elig0  = bus.req0 & ~bus.boot_mode;
        elig1  = bus.req1;
        win1   = elig1 & (~elig0 | prio_q);
        win_we = win1 ? bus.we1 : bus.we0;
    end

    always_comb begin
        state_d    = state_q;
        rd_owner_d = rd_owner_q;
        prio_d     = prio_q;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        rvalid0    = 1'b0;
        rvalid1    = 1'b0;
        rdata0     = '0;
        rdata1     = '0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = bus.addr0;
        mem_wdata  = bus.wdata0;

        if (!rst) begin
            if (state_q == ST_RD_WAIT) begin
                rvalid0 = ~rd_owner_q;
                rvalid1 = rd_owner_q;
                rdata0  = rd_owner_q ? '0 : bus.mem_rdata;
                rdata1  = rd_owner_q ? bus.mem_rdata : '0;
                state_d = ST_IDLE;
            end else if (elig0 || elig1) begin
                gnt0   = ~win1;
                gnt1   = win1;
                mem_we = win_we;
                mem_re = ~win_we;
                if (win1) begin
                    mem_addr  = bus.addr1;
                    mem_wdata = bus.wdata1;
                end
                // The loser of this grant gets the next tie.
                prio_d = ~win1;
                if (!win_we) begin
                    rd_owner_d = win1;
                    state_d    = ST_RD_WAIT;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rd_owner_q <= 1'b0;
            prio_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_owner_q <= rd_owner_d;
            prio_q     <= prio_d;
        end
    end

    assign bus.gnt0      = gnt0;
    assign bus.gnt1      = gnt1;
    assign bus.rvalid0   = rvalid0;
    assign bus.rvalid1   = rvalid1;
    assign bus.rdata0    = rdata0;
    assign bus.rdata1    = rdata1;
    assign bus.mem_re    = mem_re;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_mem_port_arbiter;
    bit clk = 1'b0;
    logic rst;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Memory macro behaviour: write at the edge, read data appears the cycle after mem_re.
    logic [31:0] mem_arr   [logic [31:0]];
    logic [31:0] model_mem [logic [31:0]];

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    always @(posedge clk) begin
        if (bus.mem_we === 1'b1) mem_arr[bus.mem_addr] = bus.mem_wdata;
        if (bus.mem_re === 1'b1)
            bus.mem_rdata <= mem_arr.exists(bus.mem_addr) ? mem_arr[bus.mem_addr] : init_val(bus.mem_addr);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: one outstanding read at most, a tie-break preference bit, and a
    // shadow memory updated by each write the model expects to be granted.
    logic        m_busy = 1'b0;
    logic        m_owner = 1'b0;
    logic [31:0] m_pend_data = '0;
    logic        m_prio = 1'b0;
    logic        exp_gnt0 = 1'b0;
    logic        exp_gnt1 = 1'b0;

    function automatic logic [31:0] model_read(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : init_val(a);
    endfunction

    always @(negedge clk) begin
        logic e0, e1, any, w1, wwe;
        logic [31:0] waddr, wdat;
        logic rv0, rv1;
        logic [31:0] rd0, rd1;
        e0 = bus.req0 && !bus.boot_mode;
        e1 = bus.req1;
        exp_gnt0 = 1'b0;
        exp_gnt1 = 1'b0;
        rv0 = 1'b0; rv1 = 1'b0; rd0 = '0; rd1 = '0;
        wwe = 1'b0; any = 1'b0; w1 = 1'b0;
        waddr = bus.addr0; wdat = bus.wdata0;
        if (rst) begin
            m_busy = 1'b0;
            m_prio = 1'b0;
            m_owner = 1'b0;
        end else if (m_busy) begin
            rv0 = (m_owner == 1'b0);
            rv1 = (m_owner == 1'b1);
            rd0 = rv0 ? m_pend_data : '0;
            rd1 = rv1 ? m_pend_data : '0;
            m_busy = 1'b0;
        end else if (e0 || e1) begin
            any = 1'b1;
            w1 = (e0 && e1) ? m_prio : e1;
            exp_gnt0 = !w1;
            exp_gnt1 = w1;
            wwe   = w1 ? bus.we1 : bus.we0;
            waddr = w1 ? bus.addr1 : bus.addr0;
            wdat  = w1 ? bus.wdata1 : bus.wdata0;
            m_prio = !w1;
            if (wwe) model_mem[waddr] = wdat;
            else begin
                m_busy = 1'b1;
                m_owner = w1;
                m_pend_data = model_read(waddr);
            end
        end
        checkOutput("gnt0", 32'(bus.gnt0), 32'(exp_gnt0));
        checkOutput("gnt1", 32'(bus.gnt1), 32'(exp_gnt1));
        checkOutput("rvalid0", 32'(bus.rvalid0), 32'(rv0));
        checkOutput("rvalid1", 32'(bus.rvalid1), 32'(rv1));
        checkOutput("rdata0", bus.rdata0, rd0);
        checkOutput("rdata1", bus.rdata1, rd1);
        checkOutput("mem_we", 32'(bus.mem_we), 32'(any && wwe));
        checkOutput("mem_re", 32'(bus.mem_re), 32'(any && !wwe));
        if (!rst && (rv0 == 1'b0) && (rv1 == 1'b0)) begin
            checkOutput("mem_addr", bus.mem_addr, waddr);
            checkOutput("mem_wdata", bus.mem_wdata, wdat);
        end
    end

    // One call per cycle: inputs change just after the rising edge, then wait to mid-cycle.
    task automatic applyStimulus(input logic r, input logic boot,
                                 input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                                 input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
        @(posedge clk);
        #1;
        rst = r; bus.boot_mode = boot;
        bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
        bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.boot_mode = 1'b0;
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
        bus.mem_rdata = '0;
        mem_arr[32'h40]   = 32'hDEADBEEF;
        model_mem[32'h40] = 32'hDEADBEEF;

        // Reset holds everything quiet even with requests present.
        applyStimulus(1, 0, 1, 0, 32'h40, 0, 1, 1, 32'h8, 32'h9);
        checkOutput("rst_gnt0", 32'(bus.gnt0), 0);
        checkOutput("rst_gnt1", 32'(bus.gnt1), 0);
        checkOutput("rst_mem_re", 32'(bus.mem_re), 0);
        checkOutput("rst_mem_we", 32'(bus.mem_we), 0);

        // Lone core read.
        applyStimulus(0, 0, 1, 0, 32'h40, 0, 0, 0, 0, 0);
        checkOutput("rd_gnt0", 32'(bus.gnt0), 1);
        checkOutput("rd_mem_re", 32'(bus.mem_re), 1);
        checkOutput("rd_mem_addr", bus.mem_addr, 32'h40);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rd_rvalid0", 32'(bus.rvalid0), 1);
        checkOutput("rd_rdata0", bus.rdata0, 32'hDEADBEEF);
        checkOutput("rd_rvalid1", 32'(bus.rvalid1), 0);
        checkOutput("rd_rdata1", bus.rdata1, 0);

        // Continuous read contention from prio = 0.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 8; c++) begin
            applyStimulus(0, 0, 1, 0, 32'h40, 0, 1, 0, 32'h44, 0);
            checkOutput($sformatf("cont_gnt0_%0d", c), 32'(bus.gnt0), 32'(c % 4 == 0));
            checkOutput($sformatf("cont_gnt1_%0d", c), 32'(bus.gnt1), 32'(c % 4 == 2));
            checkOutput($sformatf("cont_rv0_%0d", c), 32'(bus.rvalid0), 32'(c % 4 == 1));
            checkOutput($sformatf("cont_rv1_%0d", c), 32'(bus.rvalid1), 32'(c % 4 == 3));
        end

        // Boot mode: loader writes back-to-back while the core is locked out.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 1, 0, 32'h4, 0, 1, 1, 32'(4 * i), 32'(8'h11 * (i + 1)));
            checkOutput($sformatf("boot_gnt1_%0d", i), 32'(bus.gnt1), 1);
            checkOutput($sformatf("boot_gnt0_%0d", i), 32'(bus.gnt0), 0);
            checkOutput($sformatf("boot_we_%0d", i), 32'(bus.mem_we), 1);
        end
        applyStimulus(0, 0, 1, 0, 32'h4, 0, 0, 0, 0, 0);
        checkOutput("unboot_gnt0", 32'(bus.gnt0), 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("unboot_rdata0", bus.rdata0, 32'h22);

        // Core write vs loader read right after reset.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 32'h200, 32'h55, 1, 0, 32'h40, 0);
        checkOutput("wr_rd_gnt0", 32'(bus.gnt0), 1);
        checkOutput("wr_rd_gnt1", 32'(bus.gnt1), 0);
        checkOutput("wr_rd_we", 32'(bus.mem_we), 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 32'h40, 0);
        checkOutput("wr_rd_gnt1b", 32'(bus.gnt1), 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("wr_rd_rvalid1", 32'(bus.rvalid1), 1);
        checkOutput("wr_rd_rdata1", bus.rdata1, 32'hDEADBEEF);

        // Reset while a loader read is in flight drops it.
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 32'h8, 0);
        checkOutput("rstrd_gnt1", 32'(bus.gnt1), 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rstrd_rvalid1", 32'(bus.rvalid1), 0);
        applyStimulus(0, 0, 1, 0, 32'h4, 0, 0, 0, 0, 0);
        checkOutput("rstrd_gnt0", 32'(bus.gnt0), 1);
        checkOutput("rstrd_rvalid1b", 32'(bus.rvalid1), 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rstrd_rdata0", bus.rdata0, 32'h22);

        // Write then read the same address.
        applyStimulus(0, 0, 1, 1, 32'h100, 32'hCAFE0001, 0, 0, 0, 0);
        checkOutput("raw_wr_gnt0", 32'(bus.gnt0), 1);
        applyStimulus(0, 0, 1, 0, 32'h100, 0, 0, 0, 0, 0);
        checkOutput("raw_rd_gnt0", 32'(bus.gnt0), 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("raw_rdata0", bus.rdata0, 32'hCAFE0001);

        // Random traffic; each requester holds its request until the model grants it.
        begin
            logic r0, w0, r1, w1, boot, r;
            logic [31:0] a0, d0, a1, d1;
            r0 = 0; w0 = 0; r1 = 0; w1 = 0; boot = 0;
            a0 = 0; d0 = 0; a1 = 0; d1 = 0;
            for (int c = 0; c < 3000; c++) begin
                if (!r0 || exp_gnt0) begin
                    r0 = ($urandom_range(0, 3) != 0);
                    w0 = $urandom_range(0, 1) == 1;
                    a0 = 32'($urandom_range(0, 15)) << 2;
                    d0 = $urandom;
                end
                if (!r1 || exp_gnt1) begin
                    r1 = ($urandom_range(0, 3) != 0);
                    w1 = $urandom_range(0, 1) == 1;
                    a1 = 32'($urandom_range(0, 15)) << 2;
                    d1 = $urandom;
                end
                if ($urandom_range(0, 19) == 0) boot = ~boot;
                r = ($urandom_range(0, 99) == 0);
                applyStimulus(r, boot, r0, w0, a0, d0, r1, w1, a1, d1);
            end
        end

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
